// File: rtl/query_patch_loader.sv
// query_patch_loader: assembles PATCH_SIZE pixel elements from an upstream
// valid/ready stream into one packed patch and writes it to query memory
// (active-low csb0/web0 strobe) at consecutive addresses, one patch per
// WRITE cycle. All outputs are registered and decoded from the next state.
//
// Build option: define QUERY_LOADER_WRAP_EN to let the write address wrap
// from DEPTH-1 back to 0 and keep loading. With it undefined, the loader
// stops in DONE after the last slot has been written.
module query_patch_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             csb0,
  output logic                             web0,
  output logic [ADDR_WIDTH-1:0]            addr0,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0,
  output logic [ADDR_WIDTH:0]              patch_count,
  output logic                             busy,
  output logic                             done
);

  localparam int PW    = DATA_WIDTH * PATCH_SIZE;
  localparam int IDX_W = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(PATCH_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]         COUNT_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        elem_idx_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [PW-1:0]           patch_q;
  logic [PW-1:0]           patch_d;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_d;
  logic                    in_ready_q;
  logic                    csb0_q;
  logic                    web0_q;
  logic [ADDR_WIDTH-1:0]   addr0_q;
  logic [PW-1:0]           wpatch0_q;
  logic                    busy_q;
  logic                    done_q;

  // Patch with the incoming element dropped into its slot, and the saturating patch count.
  always_comb begin
    patch_d = patch_q;
    for (int k = 0; k < PATCH_SIZE; k++) begin
      if (elem_idx_q == IDX_W'(k)) begin
        patch_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end else begin
        patch_d[k*DATA_WIDTH +: DATA_WIDTH] = patch_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (count_q >= COUNT_MAX) begin
      count_d = COUNT_MAX;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Load FSM: state, counters, patch buffer and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      elem_idx_q <= '0;
      waddr_q    <= '0;
      patch_q    <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      csb0_q     <= 1'b1;
      web0_q     <= 1'b1;
      addr0_q    <= '0;
      wpatch0_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_FILL;
            elem_idx_q <= '0;
            waddr_q    <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_FILL: begin
          if (in_valid && in_ready_q) begin
            patch_q <= patch_d;
            if (elem_idx_q == LAST_IDX) begin
              state_q    <= S_WRITE;
              elem_idx_q <= '0;
              in_ready_q <= 1'b0;
              csb0_q     <= 1'b0;
              web0_q     <= 1'b0;
              addr0_q    <= waddr_q;
              wpatch0_q  <= patch_d;
            end else begin
              elem_idx_q <= elem_idx_q + IDX_W'(1);
            end
          end
        end
        S_WRITE: begin
          csb0_q  <= 1'b1;
          web0_q  <= 1'b1;
          count_q <= count_d;
          if (waddr_q == LAST_ADDR) begin
            waddr_q <= '0;
`ifdef QUERY_LOADER_WRAP_EN
            state_q    <= S_FILL;
            in_ready_q <= 1'b1;
`else
            state_q    <= S_DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            waddr_q    <= waddr_q + ADDR_WIDTH'(1);
            state_q    <= S_FILL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          csb0_q     <= 1'b1;
          web0_q     <= 1'b1;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign csb0        = csb0_q;
  assign web0        = web0_q;
  assign addr0       = addr0_q;
  assign wpatch0     = wpatch0_q;
  assign patch_count = count_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_query_patch_loader.sv
// Directed bench for query_patch_loader. Inputs change 1 ns after the rising
// edge; outputs are sampled there too. Expected values are hand-derived.
module tb_query_patch_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        csb0;
  logic        web0;
  logic [8:0]  addr0;
  logic [54:0] wpatch0;
  logic [9:0]  patch_count;
  logic        busy;
  logic        done;

  int total;
  int bad;

  query_patch_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .csb0        (csb0),
    .web0        (web0),
    .addr0       (addr0),
    .wpatch0     (wpatch0),
    .patch_count (patch_count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Send five back-to-back elements base..base+4, check the WRITE cycle, then
  // advance one cycle past it.
  task automatic feed_patch(input string tag, input logic [10:0] base, input logic [8:0] exp_addr);
    logic [54:0] exp_patch;
    logic [10:0] v;
    exp_patch = '0;
    for (int e = 0; e < 5; e++) begin
      v = base + 11'(e);
      exp_patch[e*11 +: 11] = v;
      in_valid = 1'b1;
      in_data  = v;
      step();
    end
    in_valid = 1'b0;
    check({tag, "_csb0"}, 64'(csb0), 64'd0);
    check({tag, "_web0"}, 64'(web0), 64'd0);
    check({tag, "_addr"}, 64'(addr0), 64'(exp_addr));
    check({tag, "_patch"}, 64'(wpatch0), 64'(exp_patch));
    check({tag, "_rdy_w"}, 64'(in_ready), 64'd0);
    step();
  endtask

  initial begin
    logic [54:0] exp_p;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 11'd0;
    step();
    step();
    // Reset values
    check("rst_rdy",   64'(in_ready), 64'd0);
    check("rst_csb",   64'(csb0), 64'd1);
    check("rst_web",   64'(web0), 64'd1);
    check("rst_addr",  64'(addr0), 64'd0);
    check("rst_patch", 64'(wpatch0), 64'd0);
    check("rst_cnt",   64'(patch_count), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    rst = 1'b0;
    // Stays idle without start even with in_valid high
    in_valid = 1'b1;
    in_data  = 11'h3FF;
    step(); step(); step();
    in_valid = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_rdy",  64'(in_ready), 64'd0);

    // Basic patch 1..5
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_rdy",  64'(in_ready), 64'd1);
    check("start_cnt",  64'(patch_count), 64'd0);
    feed_patch("p1", 11'd1, 9'd0);
    check("p1_packed", 64'(wpatch0), 64'({11'd5, 11'd4, 11'd3, 11'd2, 11'd1}));
    check("p1_cnt",    64'(patch_count), 64'd1);
    check("p1_csb_hi", 64'(csb0), 64'd1);
    check("p1_addr_h", 64'(addr0), 64'd0);
    check("p1_rdy",    64'(in_ready), 64'd1);

    // Toggling in_valid: two patches at addresses 0 and 1
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    pulse_start();
    for (int p = 0; p < 2; p++) begin
      exp_p = '0;
      for (int e = 0; e < 5; e++) begin
        exp_p[e*11 +: 11] = 11'h100 + 11'(p*16 + e);
        in_valid = 1'b1;
        in_data  = 11'h100 + 11'(p*16 + e);
        step();
        in_valid = 1'b0;
        in_data  = 11'h7FF;
        if (e < 4) begin
          check("tog_rdy_a", 64'(in_ready), 64'd1);
          check("tog_csb_a", 64'(csb0), 64'd1);
          step();
          check("tog_rdy_b", 64'(in_ready), 64'd1);
        end else begin
          check("tog_w_csb",  64'(csb0), 64'd0);
          check("tog_w_rdy",  64'(in_ready), 64'd0);
          check("tog_w_addr", 64'(addr0), 64'(p));
          check("tog_w_data", 64'(wpatch0), 64'(exp_p));
          step();
          check("tog_f_rdy",  64'(in_ready), 64'd1);
          check("tog_f_cnt",  64'(patch_count), 64'(p + 1));
        end
      end
    end

    // start during FILL is ignored
    in_valid = 1'b1;
    in_data  = 11'h20;
    step();
    in_data  = 11'h21;
    step();
    in_valid = 1'b0;
    pulse_start();
    check("ign_busy", 64'(busy), 64'd1);
    check("ign_cnt",  64'(patch_count), 64'd2);
    check("ign_rdy",  64'(in_ready), 64'd1);
    exp_p = {11'h24, 11'h23, 11'h22, 11'h21, 11'h20};
    for (int e = 2; e < 5; e++) begin
      in_valid = 1'b1;
      in_data  = 11'h20 + 11'(e);
      step();
    end
    in_valid = 1'b0;
    check("ign_w_csb",  64'(csb0), 64'd0);
    check("ign_w_addr", 64'(addr0), 64'd2);
    check("ign_w_data", 64'(wpatch0), 64'(exp_p));
    step();
    check("ign_cnt3", 64'(patch_count), 64'd3);

    // Reset coincident with WRITE aborts the strobe immediately
    for (int e = 0; e < 5; e++) begin
      in_valid = 1'b1;
      in_data  = 11'h40 + 11'(e);
      step();
    end
    in_valid = 1'b0;
    check("rw_csb_lo", 64'(csb0), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rw_csb_hi", 64'(csb0), 64'd1);
    check("rw_web_hi", 64'(web0), 64'd1);
    check("rw_cnt",    64'(patch_count), 64'd0);
    check("rw_addr",   64'(addr0), 64'd0);
    step();
    rst = 1'b0;
    pulse_start();

    // Reset mid-FILL discards the partial patch
    for (int e = 0; e < 3; e++) begin
      in_valid = 1'b1;
      in_data  = 11'h55 + 11'(e);
      step();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rf_rdy",  64'(in_ready), 64'd0);
    check("rf_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    step(); step();
    check("rf_idle", 64'(busy), 64'd0);
    pulse_start();
    feed_patch("rf_new", 11'h600, 9'd0);
    check("rf_cnt", 64'(patch_count), 64'd1);

    // Fill the whole memory
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    pulse_start();
    for (int p = 0; p < 512; p++) begin
      feed_patch("full", 11'(p * 5), 9'(p));
      check("full_cnt", 64'(patch_count), 64'(p + 1));
    end
`ifdef QUERY_LOADER_WRAP_EN
    check("wrap_done", 64'(done), 64'd0);
    check("wrap_rdy",  64'(in_ready), 64'd1);
    feed_patch("wrap513", 11'h123, 9'd0);
    check("wrap_cnt",  64'(patch_count), 64'd512);
    check("wrap_done2", 64'(done), 64'd0);
`else
    check("end_done", 64'(done), 64'd1);
    check("end_busy", 64'(busy), 64'd0);
    check("end_rdy",  64'(in_ready), 64'd0);
    check("end_cnt",  64'(patch_count), 64'd512);
    in_valid = 1'b1;
    in_data  = 11'h11;
    for (int i = 0; i < 8; i++) begin
      step();
      check("end_nowr", 64'(csb0), 64'd1);
    end
    in_valid = 1'b0;
    check("end_cnt2", 64'(patch_count), 64'd512);
    pulse_start();
    check("re_busy", 64'(busy), 64'd1);
    check("re_cnt",  64'(patch_count), 64'd0);
    check("re_done", 64'(done), 64'd0);
    feed_patch("re_p", 11'h77, 9'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
